regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised multi-port integer register file with an integrated pending-write scoreboard. It sits between decode (read ports, scoreboard set) and the writeback stages (write ports), replacing the fixed 2-read/1-write file. It adds configurable port counts, same-cycle write bypass, asynchronous clearing of all registers, and per-register "result pending" tracking. Decode uses this tracking to stall on long-latency producers such as loads and dividers.

## Interface
Parameters:
- XLEN, 32: data width.
- NREG, 32: number of registers; AW = $clog2(NREG).
- NRD, 2: number of read ports.
- NWR, 2: number of write ports; higher index has priority.
- BYPASS, 1: 1 forwards same-cycle write data to read ports; 0 means no forwarding.

Ports. Clock and reset come first. Vectors are flattened, and port k occupies slice [k*W +: W].
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- raddr_i  in  NRD*AW  read addresses.
- rdata_o  out  NRD*XLEN  read data, combinational.
- rvalid_o  out  NRD  1 = read data is final, with no pending write to that register.
- we_i  in  NWR  write enables.
- waddr_i  in  NWR*AW  write addresses.
- wdata_i  in  NWR*XLEN  write data.
- set_i  in  1  mark a register pending: a producer has been issued.
- set_addr_i  in  AW  register to mark.
- flush_i  in  1  clear all pending bits; synchronous.
- pending_o  out  NREG  registered pending vector, for debug and stall logic.

## Operation
- Storage is regs[0..NREG-1] of XLEN bits, plus pend[0..NREG-1].
- Register 0 is hardwired:
  - reads of 0 return 0 with rvalid=1;
  - writes to 0 are dropped;
  - set_i to 0 is ignored;
  - pend[0] is always 0.
- Write, per clock edge:
  - For each register r≠0, the winning write is the highest-index port k with we_i[k] and waddr k == r.
  - regs[r] <= winning wdata.
  - Lower-index ports to the same address are discarded.
- Pending update, per register r≠0, in priority order:
  - flush_i → 0;
  - else set_i && set_addr_i==r → 1;
  - else any write to r → 0;
  - else hold.
  - Set beats a same-cycle clear, because the new producer is issued after the old one completes.
  - Flush beats set.
- Read port j, combinational, with a = raddr j:
  - a==0 → data 0, valid 1.
  - else if BYPASS and any we_i[k] with waddr k == a → data is the winning wdata, valid 1.
  - else → data regs[a], valid !pend[a].
- Same-cycle set_i does not affect rvalid_o. It takes effect from the next cycle.
- Addresses ≥ NREG, when NREG is not a power of 2:
  - reads return 0 with valid 1;
  - writes and sets are ignored.

## Timing
- Reset (rst_n low, asynchronous):
  - all regs and pend cleared immediately;
  - rdata_o = 0, rvalid_o = 0, pending_o = 0, held while rst_n is low.
  - After release, the first edge may write.
- Write latency:
  - BYPASS=1: 0 cycles to read ports (same cycle).
  - BYPASS=0: 1 cycle; the data is visible from the cycle after the edge.
- Pending latency:
  - set at edge N gives rvalid=0 from cycle N+1;
  - a clearing write at edge M gives rvalid=1 in cycle M with BYPASS=1, or from M+1 with BYPASS=0.
- pending_o is a direct register output with no combinational path from inputs.
- Reset asserted mid-operation: all state is lost and no write completes on the edge that coincides with reset assertion.

## Test plan
- Reset then read all: assert rst_n=0 with random inputs → rdata_o=0 and rvalid_o=0. Release, then read r1..r31 on all ports → 0 with valid 1.
- Write/read and x0: write r5=0xDEADBEEF on port 0 and r0=0x1234 on port 1. The next cycle, port 0 reads r5 and port 1 reads r0 → 0xDEADBEEF valid 1, and 0 valid 1.
- Write conflict and bypass: in one cycle, port 0 writes r7=0x11 and port 1 writes r7=0x22, while reading r7.
  - BYPASS=1: same-cycle read = 0x22; the next cycle = 0x22.
  - BYPASS=0: same-cycle read = the old value; the next cycle = 0x22.
- Scoreboard: set r9 at edge N → rvalid for r9 = 0 in cycles N+1..M. Write r9=0x55 at edge M → read 0x55 with valid 1 (BYPASS=1 in cycle M).
- Set/clear collision and flush:
  - Same edge: set r3 and write r3 → pend[3]=1 afterwards.
  - Then flush_i together with set r4 → pending_o = 0.
- Async reset mid-stream: pulse rst_n low between edges while writes are active → all regs and pending bits read 0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb
//   Parametrised multi-port integer register file with an integrated
//   pending-write scoreboard. Register 0 is hardwired to zero and is never
//   pending. Higher-index write ports win when several target the same
//   register in one cycle.
//
// Ports
//   clk         in   clock, all state changes on the rising edge
//   rst_n       in   asynchronous active-low reset, clears regs and pending
//   raddr_i     in   NRD*AW    read addresses, port k at [k*AW +: AW]
//   rdata_o     out  NRD*XLEN  combinational read data
//   rvalid_o    out  NRD       1 = data is final (no outstanding producer)
//   we_i        in   NWR       write enables
//   waddr_i     in   NWR*AW    write addresses
//   wdata_i     in   NWR*XLEN  write data
//   set_i       in   mark set_addr_i pending (producer issued)
//   set_addr_i  in   AW        register to mark
//   flush_i     in   synchronously clear every pending bit
//   pending_o   out  NREG      registered pending vector
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    raddr_i,
  output logic [NRD*XLEN-1:0]  rdata_o,
  output logic [NRD-1:0]       rvalid_o,
  input  logic [NWR-1:0]       we_i,
  input  logic [NWR*AW-1:0]    waddr_i,
  input  logic [NWR*XLEN-1:0]  wdata_i,
  input  logic                 set_i,
  input  logic [AW-1:0]        set_addr_i,
  input  logic                 flush_i,
  output logic [NREG-1:0]      pending_o
);

  // Flattened view of the register contents and pending bits, index 0
  // tied to zero so the read mux needs no special case for storage.
  logic [NREG*XLEN-1:0] reg_flat;
  logic [NREG-1:0]      pend_vec;

  assign reg_flat[XLEN-1:0] = '0;
  assign pend_vec[0]        = 1'b0;

  genvar gi;

  // One storage slot per architectural register (1..NREG-1). Addresses at
  // or above NREG never match any slot, so such writes and sets vanish.
  for (gi = 1; gi < NREG; gi++) begin : g_reg
    logic            hit;
    logic [XLEN-1:0] win_data;
    logic [XLEN-1:0] data_reg;
    logic            pend_reg;
    logic            pend_next;

    // Later iterations overwrite earlier ones, so the highest-index
    // matching port supplies the data.
    always_comb begin
      hit      = 1'b0;
      win_data = '0;
      for (int k = 0; k < NWR; k++) begin
        if (we_i[k] && (waddr_i[k*AW +: AW] == AW'(gi))) begin
          hit      = 1'b1;
          win_data = wdata_i[k*XLEN +: XLEN];
        end
      end
    end

    // Set outranks a same-cycle completing write: the new producer was
    // issued after the one now writing back, so the register stays busy.
    always_comb begin
      pend_next = pend_reg;
      if (flush_i) begin
        pend_next = 1'b0;
      end else if (set_i && (set_addr_i == AW'(gi))) begin
        pend_next = 1'b1;
      end else if (hit) begin
        pend_next = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_reg <= '0;
        pend_reg <= 1'b0;
      end else begin
        if (hit) begin
          data_reg <= win_data;
        end
        pend_reg <= pend_next;
      end
    end

    assign reg_flat[gi*XLEN +: XLEN] = data_reg;
    assign pend_vec[gi]              = pend_reg;
  end

  assign pending_o = pend_vec;

  // Read ports.
  for (gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            in_range;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;
    logic [XLEN-1:0] data;
    logic            valid;

    assign addr     = raddr_i[gi*AW +: AW];
    assign in_range = ({1'b0, addr} < (AW+1)'(NREG));

    always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int k = 0; k < NWR; k++) begin
        if (we_i[k] && (waddr_i[k*AW +: AW] == addr)) begin
          byp_hit  = 1'b1;
          byp_data = wdata_i[k*XLEN +: XLEN];
        end
      end
    end

    // Outputs are forced low during reset, including reads of register 0.
    always_comb begin
      data  = '0;
      valid = 1'b0;
      if (!rst_n) begin
        data  = '0;
        valid = 1'b0;
      end else if ((addr == '0) || !in_range) begin
        data  = '0;
        valid = 1'b1;
      end else if ((BYPASS != 0) && byp_hit) begin
        // A same-cycle write is final data even if the register is pending.
        data  = byp_data;
        valid = 1'b1;
      end else begin
        data  = reg_flat[int'(addr)*XLEN +: XLEN];
        valid = !pend_vec[addr];
      end
    end

    assign rdata_o[gi*XLEN +: XLEN] = data;
    assign rvalid_o[gi]             = valid;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb. Two instances share all inputs, one
// with same-cycle bypass and one without, and are checked against a
// directed vector table and against an array-based reference model.
module tb_regfile_sb;

  logic        clk;
  logic        rst_n;
  logic [1:0]  we;
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [4:0]  ra [2];
  logic        set;
  logic [4:0]  sa;
  logic        flush;

  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [9:0]  raddr;

  assign waddr = {wa[1], wa[0]};
  assign wdata = {wd[1], wd[0]};
  assign raddr = {ra[1], ra[0]};

  logic [63:0] rdata_b, rdata_n;
  logic [1:0]  rvalid_b, rvalid_n;
  logic [31:0] pend_b, pend_n;

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_b),
    .rvalid_o(rvalid_b), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .set_i(set), .set_addr_i(sa), .flush_i(flush), .pending_o(pend_b)
  );

  regfile_sb #(.XLEN(32), .NREG(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata_n),
    .rvalid_o(rvalid_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .set_i(set), .set_addr_i(sa), .flush_i(flush), .pending_o(pend_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: architectural register contents and pending flags.
  logic [31:0] m_regs [32];
  logic        m_pend [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_pend[r] = 1'b0;
    end
  endtask

  // What a read port should show this cycle, from the current inputs.
  task automatic model_read(input bit byp, input int a, output logic [31:0] d, output logic v);
    bit hit;
    d = '0;
    v = 1'b0;
    hit = 1'b0;
    if (!rst_n) begin
      d = '0; v = 1'b0;
    end else if (a == 0) begin
      d = '0; v = 1'b1;
    end else begin
      if (byp) begin
        for (int k = 0; k < 2; k++) begin
          if (we[k] && int'(wa[k]) == a) begin
            hit = 1'b1;
            d = wd[k];
          end
        end
      end
      if (hit) begin
        v = 1'b1;
      end else begin
        d = m_regs[a];
        v = !m_pend[a];
      end
    end
  endtask

  function automatic logic [31:0] model_pend_vec();
    logic [31:0] p;
    for (int r = 0; r < 32; r++) p[r] = m_pend[r];
    return p;
  endfunction

  // Clock-edge effect of the current inputs on the reference state.
  task automatic model_update();
    bit written [32];
    for (int r = 0; r < 32; r++) written[r] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (we[k] && wa[k] != 0) begin
        m_regs[wa[k]] = wd[k];
        written[wa[k]] = 1'b1;
      end
    end
    for (int r = 1; r < 32; r++) begin
      if (flush) m_pend[r] = 1'b0;
      else if (set && int'(sa) == r) m_pend[r] = 1'b1;
      else if (written[r]) m_pend[r] = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [31:0] d;
    logic v;
    for (int j = 0; j < 2; j++) begin
      model_read(1'b1, int'(ra[j]), d, v);
      chk($sformatf("%s byp rdata%0d r%0d", tag, j, ra[j]), rdata_b[j*32 +: 32], d);
      chk($sformatf("%s byp rvalid%0d r%0d", tag, j, ra[j]), {31'b0, rvalid_b[j]}, {31'b0, v});
      model_read(1'b0, int'(ra[j]), d, v);
      chk($sformatf("%s nobyp rdata%0d r%0d", tag, j, ra[j]), rdata_n[j*32 +: 32], d);
      chk($sformatf("%s nobyp rvalid%0d r%0d", tag, j, ra[j]), {31'b0, rvalid_n[j]}, {31'b0, v});
    end
    chk($sformatf("%s byp pending", tag), pend_b, model_pend_vec());
    chk($sformatf("%s nobyp pending", tag), pend_n, model_pend_vec());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " byp rdata"}, rdata_b[31:0] | rdata_b[63:32], 32'h0);
    chk({tag, " byp rvalid"}, {30'b0, rvalid_b}, 32'h0);
    chk({tag, " byp pending"}, pend_b, 32'h0);
    chk({tag, " nobyp rdata"}, rdata_n[31:0] | rdata_n[63:32], 32'h0);
    chk({tag, " nobyp rvalid"}, {30'b0, rvalid_n}, 32'h0);
    chk({tag, " nobyp pending"}, pend_n, 32'h0);
  endtask

  task automatic idle_inputs();
    we = 2'b00; wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    ra[0] = 0; ra[1] = 0; set = 1'b0; sa = 0; flush = 1'b0;
  endtask

  // One cycle: inputs already applied; check mid-cycle, then advance.
  task automatic step(input string tag);
    @(negedge clk);
    check_model(tag);
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0; logic [31:0] wd0;
    logic [4:0]  wa1; logic [31:0] wd1;
    logic [4:0]  ra0; logic [4:0]  ra1;
    logic        set; logic [4:0]  sa;  logic flush;
    logic [31:0] bd0; logic bv0; logic [31:0] bd1; logic bv1;
    logic [31:0] nd0; logic nv0; logic [31:0] nd1; logic nv1;
    logic [31:0] pend;
  } vec_t;

  vec_t tbl [13];

  initial begin
    // Directed sequence; expectations are for the cycle before each edge.
    tbl[0]  = '{2'b11, 5'd5, 32'hDEADBEEF, 5'd0, 32'h1234, 5'd5, 5'd0, 0, 5'd0, 0,
                32'hDEADBEEF, 1, 32'h0, 1, 32'h0, 1, 32'h0, 1, 32'h0};
    tbl[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd0, 0, 5'd0, 0,
                32'hDEADBEEF, 1, 32'h0, 1, 32'hDEADBEEF, 1, 32'h0, 1, 32'h0};
    tbl[2]  = '{2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 5'd7, 5'd7, 0, 5'd0, 0,
                32'h22, 1, 32'h22, 1, 32'h0, 1, 32'h0, 1, 32'h0};
    tbl[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 0, 5'd0, 0,
                32'h22, 1, 32'h22, 1, 32'h22, 1, 32'h22, 1, 32'h0};
    tbl[4]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 1, 5'd9, 0,
                32'h0, 1, 32'h0, 1, 32'h0, 1, 32'h0, 1, 32'h0};
    tbl[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 0, 5'd0, 0,
                32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h200};
    tbl[6]  = tbl[5];
    tbl[7]  = '{2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 5'd9, 5'd9, 0, 5'd0, 0,
                32'h55, 1, 32'h55, 1, 32'h0, 0, 32'h0, 0, 32'h200};
    tbl[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9, 0, 5'd0, 0,
                32'h55, 1, 32'h55, 1, 32'h55, 1, 32'h55, 1, 32'h0};
    tbl[9]  = '{2'b10, 5'd0, 32'h0, 5'd3, 32'hAA, 5'd3, 5'd3, 1, 5'd3, 0,
                32'hAA, 1, 32'hAA, 1, 32'h0, 1, 32'h0, 1, 32'h0};
    tbl[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 0, 5'd0, 0,
                32'hAA, 0, 32'hAA, 0, 32'hAA, 0, 32'hAA, 0, 32'h8};
    tbl[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4, 1, 5'd4, 1,
                32'hAA, 0, 32'h0, 1, 32'hAA, 0, 32'h0, 1, 32'h8};
    tbl[12] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4, 0, 5'd0, 0,
                32'hAA, 1, 32'h0, 1, 32'hAA, 1, 32'h0, 1, 32'h0};

    model_clear();

    // Reset with random inputs: outputs held at zero across clock edges.
    rst_n = 1'b0;
    we = 2'($urandom_range(0, 3));
    for (int k = 0; k < 2; k++) begin
      wa[k] = 5'($urandom_range(0, 31));
      wd[k] = $urandom;
      ra[k] = 5'($urandom_range(0, 31));
    end
    set = 1'b1; sa = 5'($urandom_range(1, 31)); flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_all_zero("reset");
    idle_inputs();
    #1 rst_n = 1'b1;

    // Every register reads zero and valid after reset.
    for (int i = 1; i < 32; i++) begin
      ra[0] = 5'(i);
      ra[1] = 5'(32 - i);
      step($sformatf("postreset r%0d", i));
    end

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      we = tbl[i].we; wa[0] = tbl[i].wa0; wd[0] = tbl[i].wd0;
      wa[1] = tbl[i].wa1; wd[1] = tbl[i].wd1;
      ra[0] = tbl[i].ra0; ra[1] = tbl[i].ra1;
      set = tbl[i].set; sa = tbl[i].sa; flush = tbl[i].flush;
      @(negedge clk);
      chk($sformatf("tbl%0d byp rdata0", i), rdata_b[31:0], tbl[i].bd0);
      chk($sformatf("tbl%0d byp rvalid0", i), {31'b0, rvalid_b[0]}, {31'b0, tbl[i].bv0});
      chk($sformatf("tbl%0d byp rdata1", i), rdata_b[63:32], tbl[i].bd1);
      chk($sformatf("tbl%0d byp rvalid1", i), {31'b0, rvalid_b[1]}, {31'b0, tbl[i].bv1});
      chk($sformatf("tbl%0d nobyp rdata0", i), rdata_n[31:0], tbl[i].nd0);
      chk($sformatf("tbl%0d nobyp rvalid0", i), {31'b0, rvalid_n[0]}, {31'b0, tbl[i].nv0});
      chk($sformatf("tbl%0d nobyp rdata1", i), rdata_n[63:32], tbl[i].nd1);
      chk($sformatf("tbl%0d nobyp rvalid1", i), {31'b0, rvalid_n[1]}, {31'b0, tbl[i].nv1});
      chk($sformatf("tbl%0d byp pending", i), pend_b, tbl[i].pend);
      chk($sformatf("tbl%0d nobyp pending", i), pend_n, tbl[i].pend);
      check_model($sformatf("tbl%0d", i));
      @(posedge clk);
      model_update();
      #1;
    end

    // Randomised traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      we = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        wa[k] = 5'($urandom_range(0, 31));
        wd[k] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) wa[1] = wa[0];
      for (int j = 0; j < 2; j++) begin
        ra[j] = ($urandom_range(0, 2) == 0) ? wa[j] : 5'($urandom_range(0, 31));
      end
      set   = ($urandom_range(0, 2) == 0);
      sa    = ($urandom_range(0, 3) == 0) ? wa[0] : 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 31) == 0);
      step($sformatf("rand%0d", c));
    end

    // Asynchronous reset pulse between edges while writes are active.
    set = 1'b0; flush = 1'b0;
    we = 2'b11; wa[0] = 5'd12; wd[0] = 32'hCAFE0001; wa[1] = 5'd13; wd[1] = 32'hCAFE0002;
    ra[0] = 5'd12; ra[1] = 5'd13;
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset immediate");
    model_clear();
    @(posedge clk);
    #1 check_all_zero("midreset edge");
    rst_n = 1'b1;
    we = 2'b00;
    step("after midreset r12 r13");
    for (int i = 1; i < 32; i += 2) begin
      ra[0] = 5'(i);
      ra[1] = 5'(i + 1 < 32 ? i + 1 : 0);
      step($sformatf("after midreset r%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
